// File: rtl/imem_boot_loader_if.sv
// Byte-stream, instruction-memory write and PE-control signals of the boot loader.
// master = stream source / system side, slave = the loader itself.
interface imem_boot_loader_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  byte_valid;
    logic [7:0]            byte_data;
    logic                  byte_ready;
    logic                  reload;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_wdata;
    logic                  pe_rst_n;
    logic                  load_done;
    logic                  load_err;

    modport master (
        output byte_valid, byte_data, reload,
        input  byte_ready, imem_we, imem_addr, imem_wdata, pe_rst_n, load_done, load_err
    );

    modport slave (
        input  byte_valid, byte_data, reload,
        output byte_ready, imem_we, imem_addr, imem_wdata, pe_rst_n, load_done, load_err
    );
endinterface

// File: rtl/imem_boot_loader.sv
// Loads a length-prefixed little-endian program image from a byte stream into the PE
// instruction memory, holding the PE in reset until the whole image has been written.
module imem_boot_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int IMEM_WORDS = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    imem_boot_loader_if.slave    bus
);
    typedef enum logic [2:0] {
        HDR0 = 3'd0,
        HDR1 = 3'd1,
        DATA = 3'd2,
        RUN  = 3'd3,
        ERR  = 3'd4
    } state_t;

    localparam logic [ADDR_WIDTH:0] WORD_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [15:0]         MAX_N    = 16'(IMEM_WORDS);

    state_t                state_r;
    logic [15:0]           count_r;
    logic [ADDR_WIDTH:0]   word_idx_r;
    logic [1:0]            byte_idx_r;
    logic [31:0]           asm_r;
    logic                  wr_pend_r;

    logic                  xfer_s;
    logic [15:0]           hdr_n_s;
    logic                  last_word_s;

    assign xfer_s      = bus.byte_valid & bus.byte_ready;
    assign hdr_n_s     = {bus.byte_data, count_r[7:0]};
    assign last_word_s = ((16'(word_idx_r) + 16'd1) == count_r);

    // Loader FSM: header parse, word assembly, memory write and PE reset release.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r        <= HDR0;
            count_r        <= 16'd0;
            word_idx_r     <= '0;
            byte_idx_r     <= 2'd0;
            asm_r          <= 32'd0;
            wr_pend_r      <= 1'b0;
            bus.byte_ready <= 1'b0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= 32'd0;
            bus.pe_rst_n   <= 1'b0;
            bus.load_done  <= 1'b0;
            bus.load_err   <= 1'b0;
        end else begin
            bus.imem_we <= 1'b0;
            case (state_r)
                HDR0: begin
                    bus.byte_ready <= 1'b1;
                    if (xfer_s) begin
                        count_r[7:0] <= bus.byte_data;
                        state_r      <= HDR1;
                    end
                end
                HDR1: begin
                    if (xfer_s) begin
                        count_r <= hdr_n_s;
                        if ((hdr_n_s == 16'd0) || (hdr_n_s > MAX_N)) begin
                            state_r        <= ERR;
                            bus.byte_ready <= 1'b0;
                            bus.load_err   <= 1'b1;
                        end else begin
                            state_r    <= DATA;
                            word_idx_r <= '0;
                            byte_idx_r <= 2'd0;
                            wr_pend_r  <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    // The write of a completed word lags its 4th byte by one edge,
                    // so asm_r can already be collecting the next word meanwhile.
                    if (wr_pend_r) begin
                        wr_pend_r      <= 1'b0;
                        bus.imem_we    <= 1'b1;
                        bus.imem_addr  <= word_idx_r[ADDR_WIDTH-1:0];
                        bus.imem_wdata <= asm_r;
                        word_idx_r     <= word_idx_r + WORD_ONE;
                        if (last_word_s) begin
                            state_r        <= RUN;
                            bus.byte_ready <= 1'b0;
                        end
                    end
                    if (xfer_s && !(wr_pend_r && last_word_s)) begin
                        asm_r      <= {bus.byte_data, asm_r[31:8]};
                        byte_idx_r <= byte_idx_r + 2'd1;
                        if (byte_idx_r == 2'd3) begin
                            wr_pend_r <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (bus.reload) begin
                        state_r       <= HDR0;
                        bus.pe_rst_n  <= 1'b0;
                        bus.load_done <= 1'b0;
                    end else begin
                        bus.pe_rst_n  <= 1'b1;
                        bus.load_done <= 1'b1;
                    end
                end
                ERR: begin
                    if (bus.reload) begin
                        state_r      <= HDR0;
                        bus.load_err <= 1'b0;
                    end else begin
                        bus.load_err <= 1'b1;
                    end
                end
                default: begin
                    state_r        <= HDR0;
                    bus.byte_ready <= 1'b0;
                    bus.pe_rst_n   <= 1'b0;
                    bus.load_done  <= 1'b0;
                    bus.load_err   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: header handling, word writes, timing,
// error paths, reload and mid-load reset.
module tb_imem_boot_loader;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    imem_boot_loader_if #(.ADDR_WIDTH(AW)) bus ();

    imem_boot_loader #(.ADDR_WIDTH(AW), .IMEM_WORDS(256)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] wmem [0:255];
    int          wcount    = 0;
    int          last_addr = 0;
    int          base;

    // Memory model: records every write strobe seen by the instruction memory.
    always @(posedge clk) begin
        if (bus.imem_we === 1'b1) begin
            wmem[bus.imem_addr] <= bus.imem_wdata;
            wcount              <= wcount + 1;
            last_addr           <= int'(bus.imem_addr);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        n = 0;
        while (bus.byte_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("byte_ready_wait", {31'd0, bus.byte_ready}, 32'd1);
        @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic idle(input int n);
        bus.byte_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_reload();
        bus.reload = 1'b1;
        @(negedge clk);
        bus.reload = 1'b0;
    endtask

    task automatic wait_run(input string tag);
        int n;
        n = 0;
        while (bus.load_done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_load_done"}, {31'd0, bus.load_done}, 32'd1);
        check({tag, "_pe_rst_n"}, {31'd0, bus.pe_rst_n}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_byte_ready"}, {31'd0, bus.byte_ready}, 32'd0);
        check({tag, "_imem_we"},    {31'd0, bus.imem_we},    32'd0);
        check({tag, "_imem_addr"},  {24'd0, bus.imem_addr},  32'd0);
        check({tag, "_imem_wdata"}, bus.imem_wdata,          32'd0);
        check({tag, "_pe_rst_n"},   {31'd0, bus.pe_rst_n},   32'd0);
        check({tag, "_load_done"},  {31'd0, bus.load_done},  32'd0);
        check({tag, "_load_err"},   {31'd0, bus.load_err},   32'd0);
    endtask

    logic [7:0] img [0:9];

    initial begin
        img[0] = 8'h02; img[1] = 8'h00; img[2] = 8'h93; img[3] = 8'h00; img[4] = 8'h50;
        img[5] = 8'h00; img[6] = 8'h13; img[7] = 8'h01; img[8] = 8'hA0; img[9] = 8'h00;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        bus.reload     = 1'b0;
        rst            = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;

        // Test 1: basic two-word load, continuous stream, exact timing
        base = wcount;
        for (int i = 0; i < 10; i++) send_byte(img[i]);
        bus.byte_valid = 1'b0;
        check("t1_pre_we",       {31'd0, bus.imem_we},  32'd0);
        check("t1_pre_pe_rst_n", {31'd0, bus.pe_rst_n}, 32'd0);
        @(negedge clk);
        check("t1_we",          {31'd0, bus.imem_we},    32'd1);
        check("t1_addr",        {24'd0, bus.imem_addr},  32'd1);
        check("t1_wdata",       bus.imem_wdata,          32'h00A00113);
        check("t1_ready_low",   {31'd0, bus.byte_ready}, 32'd0);
        check("t1_pe_still_rst",{31'd0, bus.pe_rst_n},   32'd0);
        @(negedge clk);
        check("t1_pe_rst_n",    {31'd0, bus.pe_rst_n},   32'd1);
        check("t1_load_done",   {31'd0, bus.load_done},  32'd1);
        check("t1_we_off",      {31'd0, bus.imem_we},    32'd0);
        check("t1_word0",       wmem[0],                 32'h00500093);
        check("t1_word1",       wmem[1],                 32'h00A00113);
        check("t1_wcount",      32'(wcount - base),      32'd2);

        // Test 6: reload while running, new image overwrites addr0
        pulse_reload();
        check("t6_pe_rst_n",  {31'd0, bus.pe_rst_n},   32'd0);
        check("t6_load_done", {31'd0, bus.load_done},  32'd0);
        check("t6_ready_low", {31'd0, bus.byte_ready}, 32'd0);
        @(negedge clk);
        check("t6_ready_high",{31'd0, bus.byte_ready}, 32'd1);
        base = wcount;
        send_byte(8'h01); send_byte(8'h00);
        send_word(32'hDEADBEEF);
        idle(0);
        wait_run("t6");
        check("t6_word0",  wmem[0],            32'hDEADBEEF);
        check("t6_wcount", 32'(wcount - base), 32'd1);

        // Test 2: stalled stream with the basic image
        pulse_reload();
        base = wcount;
        for (int i = 0; i < 10; i++) begin
            if ($urandom_range(0, 1) == 1) idle(2);
            send_byte(img[i]);
        end
        idle(0);
        wait_run("t2");
        idle(3);
        check("t2_word0",  wmem[0],            32'h00500093);
        check("t2_word1",  wmem[1],            32'h00A00113);
        check("t2_wcount", 32'(wcount - base), 32'd2);

        // Test 3: empty image then recovery
        pulse_reload();
        base = wcount;
        send_byte(8'h00); send_byte(8'h00);
        idle(0);
        check("t3_load_err",  {31'd0, bus.load_err},   32'd1);
        check("t3_ready",     {31'd0, bus.byte_ready}, 32'd0);
        idle(3);
        check("t3_pe_rst_n",  {31'd0, bus.pe_rst_n},   32'd0);
        check("t3_no_write",  32'(wcount - base),      32'd0);
        pulse_reload();
        check("t3_err_clear", {31'd0, bus.load_err},   32'd0);
        send_byte(8'h02); send_byte(8'h00);
        send_word(32'h44332211); send_word(32'h88776655);
        idle(0);
        wait_run("t3");
        check("t3_word0",  wmem[0],            32'h44332211);
        check("t3_word1",  wmem[1],            32'h88776655);
        check("t3_wcount", 32'(wcount - base), 32'd2);

        // Test 4: N=257 rejected, N=256 fills the memory
        pulse_reload();
        send_byte(8'h01); send_byte(8'h01);
        idle(0);
        check("t4_257_err", {31'd0, bus.load_err}, 32'd1);
        pulse_reload();
        base = wcount;
        send_byte(8'h00); send_byte(8'h01);
        for (int i = 0; i < 256; i++) send_word(32'hC0DE0000 | 32'(i));
        idle(0);
        wait_run("t4");
        check("t4_wcount",    32'(wcount - base), 32'd256);
        check("t4_last_addr", 32'(last_addr),     32'd255);
        check("t4_word0",     wmem[0],            32'hC0DE0000);
        check("t4_word128",   wmem[128],          32'hC0DE0080);
        check("t4_word255",   wmem[255],          32'hC0DE00FF);
        check("t4_no_err",    {31'd0, bus.load_err}, 32'd0);

        // Test 5: reset mid-load, then fresh one-word image
        pulse_reload();
        send_byte(8'h03); send_byte(8'h00);
        for (int i = 0; i < 6; i++) send_byte(8'h11);
        bus.byte_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("t5_reset");
        rst = 1'b1;
        base = wcount;
        send_byte(8'h01); send_byte(8'h00);
        send_word(32'h12345678);
        idle(0);
        wait_run("t5");
        check("t5_word0",  wmem[0],            32'h12345678);
        check("t5_wcount", 32'(wcount - base), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
